// File: rtl/ex_stage_reg_alu_pkg.sv
// Shared types and constants for the RV32I execute stage.
// ALU selection codes mirror the shared decode encoding; unlisted codes yield zero.
package ex_stage_reg_alu_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_UI   = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                        input logic sign_r);
    add_overflow = (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/ex_stage_reg_alu_core.sv
// Combinational ALU: result plus Z/C/V/N flags from a 4-bit selection code.
// C and V are only meaningful for ADD/SUB and are forced to 0 otherwise.
module alu_core
  import ex_stage_reg_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   alu_sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         z,
  output logic         c,
  output logic         v,
  output logic         n
);

  localparam int SHW = $clog2(W);

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [SHW-1:0] w_shamt;
  logic           w_lt_s;
  logic           w_lt_u;
  logic           w_v_add;
  logic           w_v_sub;

  // SUB reuses the carry convention a + ~b + 1, so carry=1 means no borrow.
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign w_shamt = b[SHW-1:0];
  assign w_lt_s  = $signed(a) < $signed(b);
  assign w_lt_u  = a < b;
  assign w_v_add = add_overflow(a[W-1], b[W-1], w_add[W-1]);
  assign w_v_sub = add_overflow(a[W-1], ~b[W-1], w_sub[W-1]);

  // Operation select and flag derivation
  always_comb begin
    result = {W{1'b0}};
    c      = 1'b0;
    v      = 1'b0;
    case (alu_op_e'(alu_sel))
      ALU_ADD: begin
        result = w_add[W-1:0];
        c      = w_add[W];
        v      = w_v_add;
      end
      ALU_SUB: begin
        result = w_sub[W-1:0];
        c      = w_sub[W];
        v      = w_v_sub;
      end
      ALU_SLL:  result = a << w_shamt;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  result = {{(W-1){1'b0}}, w_lt_s};
      ALU_SLTU: result = {{(W-1){1'b0}}, w_lt_u};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_UI:   result = b;
      ALU_PASS: result = a;
      default:  result = {W{1'b0}};
    endcase
    z = (result == {W{1'b0}});
    n = result[W-1];
  end

endmodule

// File: rtl/ex_stage_reg_alu.sv
// Execute stage: ALU plus EX/MEM output register with valid/ready on both sides.
// A flush kills both the held op and any op offered in the same cycle.
module ex_stage_reg_alu
  import ex_stage_reg_alu_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int RD_W_P = RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_sel,
  input  logic [XLEN_P-1:0] op_a,
  input  logic [XLEN_P-1:0] op_b,
  input  logic [RD_W_P-1:0] rd_in,
  input  logic              wr_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_n,
  output logic [RD_W_P-1:0] rd_out,
  output logic              wr_en_out
);

  logic [XLEN_P-1:0] w_result;
  logic              w_z;
  logic              w_c;
  logic              w_v;
  logic              w_n;
  logic              w_in_ready;
  logic              w_accept;

  logic              r_valid;
  logic [XLEN_P-1:0] r_result;
  logic              r_z;
  logic              r_c;
  logic              r_v;
  logic              r_n;
  logic [RD_W_P-1:0] r_rd;
  logic              r_wr_en;

  alu_core #(
    .W (XLEN_P)
  ) u_alu_core (
    .alu_sel (alu_sel),
    .a       (op_a),
    .b       (op_b),
    .result  (w_result),
    .z       (w_z),
    .c       (w_c),
    .v       (w_v),
    .n       (w_n)
  );

  // Empty slot or a slot draining this cycle can take a new op with no bubble.
  assign w_in_ready = ~r_valid | out_ready;
  assign w_accept   = in_valid & w_in_ready;

  // EX/MEM register: flush has priority, then accept, then consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= {XLEN_P{1'b0}};
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_rd     <= {RD_W_P{1'b0}};
      r_wr_en  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_result;
      r_z      <= w_z;
      r_c      <= w_c;
      r_v      <= w_v;
      r_n      <= w_n;
      r_rd     <= rd_in;
      r_wr_en  <= wr_en_in;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_n    = r_n;
  assign rd_out    = r_rd;
  assign wr_en_out = r_wr_en;

endmodule

// File: tb/tb_ex_stage_reg_alu.sv
// Randomized plus directed bench for ex_stage_reg_alu against a queue-based
// reference model that computes results with plain wide arithmetic.
module tb_ex_stage_reg_alu;
  import ex_stage_reg_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        wr_en_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_z, flag_c, flag_v, flag_n;
  logic [4:0]  rd_out;
  logic        wr_en_out;

  always #5 clk = ~clk;

  ex_stage_reg_alu dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .wr_en_in  (wr_en_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .rd_out    (rd_out),
    .wr_en_out (wr_en_out)
  );

  typedef struct {
    logic [31:0] res;
    logic        z, c, v, n;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic we);
    exp_t   e;
    longint sa, sb, wide;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    e.res = 32'd0; e.c = 1'b0; e.v = 1'b0;
    case (sel)
      ALU_ADD: begin
        e.res = a + b;
        e.c   = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        wide  = sa + sb;
        e.v   = wide != longint'($signed(e.res));
      end
      ALU_SUB: begin
        e.res = a - b;
        e.c   = a >= b;
        wide  = sa - sb;
        e.v   = wide != longint'($signed(e.res));
      end
      ALU_SLL:  e.res = a << sh;
      ALU_SRL:  e.res = a >> sh;
      ALU_SRA:  e.res = $unsigned($signed(a) >>> sh);
      ALU_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      ALU_XOR:  e.res = a ^ b;
      ALU_OR:   e.res = a | b;
      ALU_AND:  e.res = a & b;
      ALU_UI:   e.res = b;
      ALU_PASS: e.res = a;
      default:  e.res = 32'd0;
    endcase
    e.z  = (e.res == 32'd0);
    e.n  = e.res[31];
    e.rd = rd;
    e.we = we;
    return e;
  endfunction

  task automatic check_out();
    check_eq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("result", result, q[0].res);
      check_eq("flags_zcvn", {flag_z, flag_c, flag_v, flag_n},
               {q[0].z, q[0].c, q[0].v, q[0].n});
      check_eq("rd_out", rd_out, q[0].rd);
      check_eq("wr_en_out", wr_en_out, q[0].we);
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input logic iv, input logic [3:0] sel, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic we,
                      input logic ordy, input logic fl);
    logic acc;
    exp_t e;
    in_valid = iv; alu_sel = sel; op_a = a; op_b = b;
    rd_in = rd; wr_en_in = we; out_ready = ordy; flush = fl;
    #1;
    check_eq("in_ready", in_ready, (q.size() == 0) || ordy);
    acc = iv && ((q.size() == 0) || ordy) && !fl;
    e = model(sel, a, b, rd, we);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  logic [31:0] corner [4];

  initial begin
    corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_sel = 4'd0;
    op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0; wr_en_in = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("reset_state", {out_valid, result, flag_z, flag_c, flag_v, flag_n, rd_out, wr_en_out}, 64'd0);
    rst = 1'b0;

    // ADD overflow
    step(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b1, 1'b0);
    check_eq("add_ovf_res", result, 32'h8000_0000);
    check_eq("add_ovf_vnc", {flag_v, flag_n, flag_c}, 3'b110);
    // SUB equal and borrow
    step(1'b1, ALU_SUB, 32'd5, 32'd5, 5'd4, 1'b1, 1'b1, 1'b0);
    check_eq("sub_eq_zc", {result, flag_z, flag_c}, {32'd0, 2'b11});
    step(1'b1, ALU_SUB, 32'd3, 32'd5, 5'd5, 1'b0, 1'b1, 1'b0);
    check_eq("sub_lt", {result, flag_c, flag_n}, {32'hFFFF_FFFE, 2'b01});
    // Shifts use b[4:0] only
    step(1'b1, ALU_SRA, 32'h8000_0000, 32'h21, 5'd6, 1'b1, 1'b1, 1'b0);
    check_eq("sra", result, 32'hC000_0000);
    step(1'b1, ALU_SRL, 32'h8000_0000, 32'h21, 5'd7, 1'b1, 1'b1, 1'b0);
    check_eq("srl", result, 32'h4000_0000);
    step(1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b1, 1'b0);
    check_eq("sltu", result, 32'd1);
    step(1'b1, ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b1, 1'b0);
    check_eq("slt", result, 32'd0);
    idle(1'b1);

    // Backpressure: second op must wait, then both arrive in order
    step(1'b1, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0000, 5'd10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ALU_OR, 32'h1, 32'h2, 5'd11, 1'b1, 1'b0, 1'b0);
      check_eq("stall_hold", result, 32'hFF00_0000);
    end
    step(1'b1, ALU_OR, 32'h1, 32'h2, 5'd11, 1'b1, 1'b1, 1'b0);
    check_eq("stall_second", {result, rd_out}, {32'd3, 5'd11});
    idle(1'b1);

    // Flush beats accept and out_ready
    step(1'b1, ALU_PASS, 32'hABCD_0123, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0);
    step(1'b1, ALU_AND, 32'hFFFF_FFFF, 32'h1234, 5'd13, 1'b1, 1'b1, 1'b1);
    check_eq("flush_valid", out_valid, 1'b0);
    idle(1'b1);
    step(1'b1, ALU_UI, 32'd0, 32'h1234_5000, 5'd14, 1'b1, 1'b1, 1'b0);
    check_eq("lui", result, 32'h1234_5000);

    // Async reset while a stalled op is held
    step(1'b1, ALU_ADD, 32'd7, 32'd8, 5'd15, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async", {out_valid, result, flag_z, flag_c, flag_v, flag_n, rd_out, wr_en_out}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
